// File: rtl/rpll_reconfig_ctrl.sv
// rtl/rpll_reconfig_ctrl.sv - rPLL lock sequencer with retry, lock-loss detection and divider reconfiguration
module rpll_reconfig_ctrl #(
    parameter int          RST_CYCLES    = 16,
    parameter int          LOCK_TIMEOUT  = 65536,
    parameter int          SETTLE_CYCLES = 1024,
    parameter int          MAX_RETRY     = 3,
    parameter int          AUTO_RELOCK   = 1,
    parameter logic [5:0]  DEF_IDSEL     = 6'd0,
    parameter logic [5:0]  DEF_FBDSEL    = 6'd9,
    parameter logic [5:0]  DEF_ODSEL     = 6'd4,
    localparam int         RC_W          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic            clkin,
    input  logic            reset,
    input  logic            pll_lock,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [5:0]      req_idsel,
    input  logic [5:0]      req_fbdsel,
    input  logic [5:0]      req_odsel,
    output logic            pll_reset,
    output logic [5:0]      idsel,
    output logic [5:0]      fbdsel,
    output logic [5:0]      odsel,
    output logic            locked,
    output logic            busy,
    output logic            err,
    output logic            lock_lost,
    output logic [RC_W-1:0] retry_cnt
);

    localparam int CNT_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX = (CNT_AB > SETTLE_CYCLES) ? CNT_AB : SETTLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [RC_W-1:0]  RETRY_LIMIT = RC_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_ASSERT_RST = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_SETTLE     = 3'd2,
        ST_LOCKED     = 3'd3,
        ST_FAIL       = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RC_W-1:0]   retry_q, retry_d;
    logic [5:0]        idsel_q, idsel_d;
    logic [5:0]        fbdsel_q, fbdsel_d;
    logic [5:0]        odsel_q, odsel_d;
    logic              locked_q, locked_d;
    logic              lock_lost_q, lock_lost_d;
    logic [1:0]        sync_q, sync_d;
    logic              lock_s;
    logic              do_retry;

    assign sync_d = {sync_q[0], pll_lock};
    assign lock_s = sync_q[1];

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= ST_ASSERT_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            idsel_q     <= DEF_IDSEL;
            fbdsel_q    <= DEF_FBDSEL;
            odsel_q     <= DEF_ODSEL;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
            sync_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            idsel_q     <= idsel_d;
            fbdsel_q    <= fbdsel_d;
            odsel_q     <= odsel_d;
            locked_q    <= locked_d;
            lock_lost_q <= lock_lost_d;
            sync_q      <= sync_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        retry_d     = retry_q;
        idsel_d     = idsel_q;
        fbdsel_d    = fbdsel_q;
        odsel_d     = odsel_q;
        locked_d    = locked_q;
        lock_lost_d = 1'b0;
        do_retry    = 1'b0;

        case (state_q)
            ST_ASSERT_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    do_retry = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!lock_s) begin
                    do_retry = 1'b1;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d  = ST_LOCKED;
                    cnt_d    = '0;
                    retry_d  = '0;
                    locked_d = 1'b1;
                end
            end
            ST_LOCKED: begin
                cnt_d = '0;
                // A request takes priority over a simultaneous lock drop.
                if (req_valid) begin
                    idsel_d  = req_idsel;
                    fbdsel_d = req_fbdsel;
                    odsel_d  = req_odsel;
                    retry_d  = '0;
                    locked_d = 1'b0;
                    state_d  = ST_ASSERT_RST;
                end else if (!lock_s) begin
                    lock_lost_d = 1'b1;
                    locked_d    = 1'b0;
                    retry_d     = '0;
                    state_d     = (AUTO_RELOCK != 0) ? ST_ASSERT_RST : ST_FAIL;
                end
            end
            ST_FAIL: begin
                cnt_d    = '0;
                locked_d = 1'b0;
                if (req_valid) begin
                    idsel_d  = req_idsel;
                    fbdsel_d = req_fbdsel;
                    odsel_d  = req_odsel;
                    retry_d  = '0;
                    state_d  = ST_ASSERT_RST;
                end
            end
            default: begin
                state_d = ST_ASSERT_RST;
                cnt_d   = '0;
            end
        endcase

        // Retries re-run the reset pulse with the configuration unchanged.
        if (do_retry) begin
            cnt_d = '0;
            if (retry_q < RETRY_LIMIT) begin
                retry_d = retry_q + RC_W'(1);
                state_d = ST_ASSERT_RST;
            end else begin
                state_d = ST_FAIL;
            end
        end
    end

    assign pll_reset = (state_q == ST_ASSERT_RST) || (state_q == ST_FAIL);
    assign busy      = (state_q == ST_ASSERT_RST) || (state_q == ST_WAIT_LOCK) ||
                       (state_q == ST_SETTLE);
    assign err       = (state_q == ST_FAIL);
    assign req_ready = (state_q == ST_LOCKED) || (state_q == ST_FAIL);
    assign idsel     = idsel_q;
    assign fbdsel    = fbdsel_q;
    assign odsel     = odsel_q;
    assign locked    = locked_q;
    assign lock_lost = lock_lost_q;
    assign retry_cnt = retry_q;

endmodule
